// File: rtl/mvm_arbiter.sv
// Round-robin arbiter/sequencer sharing one mvm crossbar between NUM_REQ requesters.
// Optional watchdog on the mvm_done wait is enabled by defining MVM_ARB_TIMEOUT_EN.
module mvm_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [NUM_REQ-1:0]         i_req_op,
   output logic [NUM_REQ-1:0]         o_grant,
   output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
   output logic [NUM_REQ-1:0]         o_done,
   output logic [NUM_REQ-1:0]         o_err,
   output logic                       o_busy,
   output logic                       o_mvm_start,
   output logic                       o_prog_wt,
   input  logic                       i_mvm_done
);
   localparam int IDXW = $clog2(NUM_REQ);

   generate
      if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
         $error("mvm_arbiter: NUM_REQ must be >= 2 and TIMEOUT >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

   state_t             r_state;
   logic [NUM_REQ-1:0] r_grant;
   logic [IDXW-1:0]    r_grant_idx;
   logic [IDXW-1:0]    r_rr_ptr;
   logic [NUM_REQ-1:0] r_done;
   logic               r_busy;
   logic               r_mvm_start;
   logic               r_prog_wt;
   logic [IDXW-1:0]    w_win;
   logic [IDXW:0]      w_j;

`ifdef MVM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]   r_cnt;
   logic [NUM_REQ-1:0] r_err;
`endif

   // Walk offsets high-to-low so the smallest offset from rr_ptr wins last.
   always_comb begin
      w_win = r_rr_ptr;
      w_j   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_j = {1'b0, r_rr_ptr} + (IDXW+1)'(k);
         if (w_j >= (IDXW+1)'(NUM_REQ)) w_j = w_j - (IDXW+1)'(NUM_REQ);
         if (i_req[w_j[IDXW-1:0]]) w_win = w_j[IDXW-1:0];
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_grant     <= '0;
         r_grant_idx <= '0;
         r_rr_ptr    <= '0;
         r_done      <= '0;
         r_busy      <= 1'b0;
         r_mvm_start <= 1'b0;
         r_prog_wt   <= 1'b0;
`ifdef MVM_ARB_TIMEOUT_EN
         r_cnt       <= '0;
         r_err       <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|i_req) begin
                  r_state     <= S_START;
                  r_grant     <= NUM_REQ'(1) << w_win;
                  r_grant_idx <= w_win;
                  r_prog_wt   <= i_req_op[w_win];
                  r_mvm_start <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            S_START: begin
               r_mvm_start <= 1'b0;
               r_state     <= S_WAIT;
`ifdef MVM_ARB_TIMEOUT_EN
               r_cnt       <= '0;
`endif
            end
            S_WAIT: begin
               if (i_mvm_done) begin
                  r_done  <= r_grant;
                  r_state <= S_DONE;
               end
`ifdef MVM_ARB_TIMEOUT_EN
               // Count reaches TIMEOUT on this WAIT cycle: give up with err.
               else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_done  <= r_grant;
                  r_err   <= r_grant;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            S_DONE: begin
               r_done    <= '0;
               r_grant   <= '0;
               r_busy    <= 1'b0;
               r_prog_wt <= 1'b0;
               r_rr_ptr  <= (r_grant_idx == IDXW'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;
               r_state   <= S_IDLE;
`ifdef MVM_ARB_TIMEOUT_EN
               r_err     <= '0;
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_grant     = r_grant;
   assign o_grant_idx = r_grant_idx;
   assign o_done      = r_done;
   assign o_busy      = r_busy;
   assign o_mvm_start = r_mvm_start;
   assign o_prog_wt   = r_prog_wt;
`ifdef MVM_ARB_TIMEOUT_EN
   assign o_err       = r_err;
`else
   assign o_err       = '0;
`endif

endmodule
